// File: rtl/lsu_mem_stage_if.sv
// Request/acknowledge bus between the MEM-stage LSU and the word-organised data SRAM.
interface lsu_mem_stage_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) ();
    logic                  bus_req;
    logic                  bus_we;
    logic [DM_ADDRESS-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32 MEM-stage load/store unit: drives a multi-cycle word SRAM, places store lanes,
// extends load data and holds the pipeline until the access completes or times out.
module lsu_mem_stage #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  lsu_stall,
    output logic                  misalign,
    output logic                  timeout_err,
    lsu_mem_stage_if.master       bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic [7:0]        wait_cnt;
    logic [1:0]        acc_lane;
    logic [2:0]        acc_func3;
    logic              acc_load;

    logic              req_any, is_load, is_byte, is_half, misaligned;
    logic              start, timed_out;
    logic [3:0]        be_next;
    logic [DATA_W-1:0] wdata_next;

    // A store wins when both request bits are set.
    assign req_any    = mem_read | mem_write;
    assign is_load    = mem_read & ~mem_write;
    assign is_byte    = (func3[1:0] == 2'b00);
    assign is_half    = (func3[1:0] == 2'b01);
    assign misaligned = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
    assign timed_out  = (wait_cnt == 8'(TIMEOUT - 1)) && !bus.bus_ack;

    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b100:  load_extend = {24'b0, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b101:  load_extend = {16'b0, h};
            default: load_extend = rdata;
        endcase
    endfunction

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wr_data;
        if (is_byte) begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{wr_data[7:0]}};
        end else if (is_half) begin
            be_next    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{wr_data[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // DONE always returns to IDLE: the request still visible there is the one just finished.
    always_comb begin
        state_next = state;
        lsu_stall  = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (req_any && !misaligned) begin
                    lsu_stall  = 1'b1;
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                lsu_stall = 1'b1;
                if (bus.bus_ack || timed_out) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data       <= '0;
            misalign      <= 1'b0;
            timeout_err   <= 1'b0;
            wait_cnt      <= '0;
            acc_lane      <= '0;
            acc_func3     <= '0;
            acc_load      <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            misalign    <= (state == IDLE) && req_any && misaligned;
            timeout_err <= (state == BUSY) && timed_out;

            if (start) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= mem_write;
                bus.bus_addr  <= {addr[DM_ADDRESS-1:2], 2'b00};
                bus.bus_be    <= be_next;
                bus.bus_wdata <= wdata_next;
                acc_lane      <= addr[1:0];
                acc_func3     <= func3;
                acc_load      <= is_load;
                wait_cnt      <= '0;
            end else if ((state == IDLE) && is_load && misaligned) begin
                rd_data <= '0;
            end

            if (state == BUSY) begin
                wait_cnt <= wait_cnt + 8'd1;
                if (bus.bus_ack) begin
                    bus.bus_req <= 1'b0;
                    if (acc_load) rd_data <= load_extend(bus.bus_rdata, acc_lane, acc_func3);
                end else if (timed_out) begin
                    bus.bus_req <= 1'b0;
                    if (acc_load) rd_data <= '0;
                end
            end
        end
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit for the MEM stage of the 5-stage RV32 pipeline; consumes the EX/MEM register outputs (MemRead, MemWrite, ALU address, forwarded store data, funct3).
- Talks to a multi-cycle, word-organised data SRAM over a req/ack bus.
- Generates byte enables and store-data lane placement, aligns and sign/zero-extends load data, and stalls the pipeline until the access completes.
- Detects misaligned accesses and bus timeouts.

Parameters:
- DM_ADDRESS, 9, byte address width of data memory.
- DATA_W, 32, data width; must be 32.
- TIMEOUT, 16, max cycles in BUSY without ack before abort; range 2..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  load request from EX/MEM
- mem_write  in  1  store request from EX/MEM
- addr  in  DM_ADDRESS  byte address (ALU result)
- wr_data  in  DATA_W  store data, unshifted
- func3  in  3  access size/sign
- rd_data  out  DATA_W  extended load result to MEM/WB
- lsu_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misalign  out  1  one-cycle pulse, misaligned access dropped
- timeout_err  out  1  one-cycle pulse, bus timeout
- bus_req  out  1  SRAM request, registered
- bus_we  out  1  1 = write
- bus_addr  out  DM_ADDRESS  word address, bits [1:0] forced to 0
- bus_be  out  4  byte enables
- bus_wdata  out  DATA_W  lane-aligned store data
- bus_rdata  in  DATA_W  SRAM read word, valid with bus_ack
- bus_ack  in  1  one-cycle completion

Behaviour:
- Reset: state IDLE; rd_data = 0; bus_req, bus_we, bus_be, bus_addr, bus_wdata, misalign and timeout_err all 0; timeout counter = 0.
- func3 decode:
  - 000 = byte signed; 100 = byte unsigned.
  - 001 = half signed; 101 = half unsigned.
  - 010, 011, 110, 111 = word.
- Misalignment:
  - half: addr[0] = 1.
  - word: addr[1:0] != 0.
- Request: mem_write = 1 takes priority over mem_read if both are set (write done, no load).
- State machine:
  - IDLE, aligned request: lsu_stall = 1 combinationally. Next edge: latch bus_addr, bus_be, bus_wdata, bus_we; bus_req = 1; go BUSY.
  - IDLE, misaligned request: no bus access; lsu_stall = 0. misalign = 1 in the following cycle only. For a load, rd_data <= 0.
  - BUSY: lsu_stall = 1; bus_req held with stable address/data; counter increments each cycle.
  - BUSY, bus_ack = 1: bus_req <= 0. For a load, rd_data <= extended bus_rdata. Go DONE.
  - BUSY, counter reaches TIMEOUT-1 with no ack: bus_req <= 0; timeout_err pulse; rd_data <= 0 for a load; go DONE.
  - DONE: lsu_stall = 0, so the pipeline advances one cycle. Next edge: IDLE, regardless of inputs, because the request seen in DONE is the completed instruction.
- Minimum latency: 3 cycles from request visible to pipeline release (IDLE, BUSY with immediate ack, DONE). Each extra wait cycle adds 1.
- rd_data holds its value until the next load completes; stores do not change it.
- Byte enables:
  - byte: be = 0001 << addr[1:0].
  - half: be = 0011 << (2*addr[1]).
  - word: 1111.
- Store lanes: wdata is replicated per size ({4{wr_data[7:0]}}, {2{wr_data[15:0]}}, or wr_data).
- Load extraction: select the byte/half at lane addr[1:0], then sign- or zero-extend to 32 bits.
- bus_ack seen in IDLE or DONE is ignored.
- Reset mid-access: bus_req drops at that edge, the access is abandoned, and a late bus_ack is ignored.

Test Plan:
- lw @0x010, ack after 1 wait cycle, bus_rdata = 0xDEADBEEF -> bus_addr = 0x010, be = 1111, lsu_stall high 3 cycles (IDLE, BUSY×2), rd_data = 0xDEADBEEF in DONE.
- lb @0x013 with bus_rdata = 0x80112233 -> be = 1000, rd_data = 0xFFFFFF80; the same access as lbu gives rd_data = 0x00000080.
- sh @0x022, wr_data = 0x0000ABCD -> bus_we = 1, bus_addr = 0x020, be = 1100, bus_wdata = 0xABCDABCD; rd_data unchanged.
- lw @0x006 -> no bus_req, lsu_stall = 0, misalign pulses once, rd_data = 0.
- sw with bus_ack tied 0, TIMEOUT = 16 -> bus_req high exactly 16 cycles, timeout_err pulses once, FSM returns to IDLE after DONE.
- reset asserted during BUSY, then bus_ack one cycle later -> bus_req = 0 after the reset edge, rd_data = 0, state IDLE, ack ignored.
